// File: rtl/multimode_ring_counter.sv
// Ring / Johnson shift counter with direction control, parallel load, hold modes,
// illegal-state detection and optional recovery to the start state on the next step.
module multimode_ring_counter #(
   parameter int WIDTH        = 8,
   parameter bit SELF_CORRECT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             err
);

   localparam logic [1:0] MODE_RING    = 2'b00;
   localparam logic [1:0] MODE_JOHNSON = 2'b01;

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("multimode_ring_counter: WIDTH must be at least 2");
      end
   endgenerate

   logic [1:0]       mode_q;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] start_cur;

   function automatic logic ring_legal(input logic [WIDTH-1:0] v);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) ones++;
      end
      return ones == 1;
   endfunction

   // Johnson codes are a block of ones against a block of zeros: at most one boundary.
   function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
      int unsigned edges;
      edges = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (v[i] != v[i+1]) edges++;
      end
      return edges <= 1;
   endfunction

   function automatic logic [WIDTH-1:0] start_of(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] s;
      s = cur;
      if (m == MODE_RING)         s = {{(WIDTH-1){1'b0}}, 1'b1};
      else if (m == MODE_JOHNSON) s = '0;
      return s;
   endfunction

   always_comb begin
      err = 1'b0;
      if (mode_q == MODE_RING)         err = !ring_legal(q);
      else if (mode_q == MODE_JOHNSON) err = !johnson_legal(q);
   end

   always_comb begin
      shifted = q;
      if (mode_q == MODE_RING)
         shifted = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
      else if (mode_q == MODE_JOHNSON)
         shifted = dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
   end

   assign start_cur = start_of(mode_q, q);

   // One action per edge: mode change, then load, then enabled step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q      <= {{(WIDTH-1){1'b0}}, 1'b1};
         mode_q <= MODE_RING;
         wrap   <= 1'b0;
      end else if (mode != mode_q) begin
         q      <= start_of(mode, q);
         mode_q <= mode;
         wrap   <= 1'b0;
      end else if (load) begin
         q    <= load_val;
         wrap <= 1'b0;
      end else if (en && !mode_q[1]) begin
         if (SELF_CORRECT && err) begin
            q    <= start_cur;
            wrap <= 1'b0;
         end else begin
            q    <= shifted;
            wrap <= !err && (shifted == start_cur);
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Scoreboard bench: two counters (recovery on / off) driven alike and compared
// every cycle against a sequence-position reference model.
module tb_multimode_ring_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         en, dir, load;
   logic [1:0]   mode;
   logic [W-1:0] load_val;
   logic [W-1:0] q_a, q_b;
   logic         wrap_a, wrap_b, err_a, err_b;

   multimode_ring_counter #(.WIDTH(W), .SELF_CORRECT(1'b1)) dut_a (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .q(q_a), .wrap(wrap_a), .err(err_a));

   multimode_ring_counter #(.WIDTH(W), .SELF_CORRECT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(load_val), .q(q_b), .wrap(wrap_b), .err(err_b));

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [1:0]   m;
      logic         wrap;
   } st_t;

   typedef struct {
      logic [W-1:0] q_a;
      logic         w_a, e_a;
      logic [W-1:0] q_b;
      logic         w_b, e_b;
   } exp_t;

   exp_t exp_q[$];
   st_t  ma, mb;
   int   n_pass = 0;
   int   n_total = 0;

   // k-th Johnson code counting from all-zeros: ones fill in from the LSB, then drain.
   function automatic logic [W-1:0] jseq(input int k);
      int v;
      if (k <= W) v = (1 << k) - 1;
      else        v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
      return v[W-1:0];
   endfunction

   function automatic int jindex(input logic [W-1:0] v);
      for (int k = 0; k < 2 * W; k++) if (jseq(k) == v) return k;
      return -1;
   endfunction

   function automatic logic m_err(input logic [W-1:0] v, input logic [1:0] m);
      if (m == 2'b00) return $countones(v) != 1;
      if (m == 2'b01) return jindex(v) < 0;
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] m_start(input logic [1:0] m);
      return (m == 2'b00) ? W'(1) : W'(0);
   endfunction

   function automatic logic [W-1:0] legal_next(input logic [W-1:0] v, input logic [1:0] m,
                                               input logic d);
      int k;
      int n;
      if (m == 2'b00) begin
         k = $clog2(int'(v));
         k = d ? (k + W - 1) % W : (k + 1) % W;
         n = 1 << k;
         return n[W-1:0];
      end
      k = jindex(v);
      k = d ? (k + 2 * W - 1) % (2 * W) : (k + 1) % (2 * W);
      return jseq(k);
   endfunction

   // Plain shift of an illegal pattern (only reached when recovery is off).
   function automatic logic [W-1:0] raw_next(input logic [W-1:0] v, input logic [1:0] m,
                                             input logic d);
      int x, msb, lsb, r;
      x   = int'(v);
      msb = (x >> (W - 1)) & 1;
      lsb = x & 1;
      if (m == 2'b01) begin
         msb = msb ^ 1;
         lsb = lsb ^ 1;
      end
      if (d) r = (x >> 1) | (lsb << (W - 1));
      else   r = ((x << 1) & ((1 << W) - 1)) | msb;
      return r[W-1:0];
   endfunction

   function automatic st_t m_step(input st_t s, input bit sc, input logic e, input logic d,
                                  input logic [1:0] m, input logic ld, input logic [W-1:0] lv);
      st_t n;
      n = s;
      n.wrap = 1'b0;
      if (m != s.m) begin
         n.m = m;
         if (m < 2) n.q = m_start(m);
      end else if (ld) begin
         n.q = lv;
      end else if (e && s.m < 2) begin
         if (m_err(s.q, s.m)) begin
            n.q = sc ? m_start(s.m) : raw_next(s.q, s.m, d);
         end else begin
            n.q = legal_next(s.q, s.m, d);
            n.wrap = (n.q == m_start(s.m));
         end
      end
      return n;
   endfunction

   function automatic st_t m_reset();
      st_t s;
      s.q = W'(1);
      s.m = 2'b00;
      s.wrap = 1'b0;
      return s;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_total++;
      if (act !== req) $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
      else n_pass++;
   endtask

   // Monitor: one expectation per edge, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q_sc1",    q_a,           e.q_a);
            chk("wrap_sc1", W'(wrap_a),    W'(e.w_a));
            chk("err_sc1",  W'(err_a),     W'(e.e_a));
            chk("q_sc0",    q_b,           e.q_b);
            chk("wrap_sc0", W'(wrap_b),    W'(e.w_b));
            chk("err_sc0",  W'(err_b),     W'(e.e_b));
         end
      end
   end

   task automatic reset_pulse();
      #1 rst = 1'b1;
      #1;
      chk("rst_q_sc1",    q_a,        W'(1));
      chk("rst_wrap_sc1", W'(wrap_a), W'(0));
      chk("rst_q_sc0",    q_b,        W'(1));
      chk("rst_wrap_sc0", W'(wrap_b), W'(0));
      rst = 1'b0;
      ma = m_reset();
      mb = m_reset();
   endtask

   task automatic cycle(input logic e, input logic d, input logic [1:0] m,
                        input logic ld, input logic [W-1:0] lv, input bit do_rst);
      exp_t x;
      @(negedge clk);
      if (do_rst) reset_pulse();
      en = e; dir = d; mode = m; load = ld; load_val = lv;
      ma = m_step(ma, 1'b1, e, d, m, ld, lv);
      mb = m_step(mb, 1'b0, e, d, m, ld, lv);
      x.q_a = ma.q; x.w_a = ma.wrap; x.e_a = m_err(ma.q, ma.m);
      x.q_b = mb.q; x.w_b = mb.wrap; x.e_b = m_err(mb.q, mb.m);
      exp_q.push_back(x);
   endtask

   initial begin
      logic [1:0] rm;
      rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
      ma = m_reset();
      mb = m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("init_q",    q_a,        W'(1));
      chk("init_wrap", W'(wrap_a), W'(0));
      chk("init_err",  W'(err_a),  W'(0));
      rst = 1'b0;

      // Ring forward: wrap on the return to 0001
      repeat (5) cycle(1, 0, 2'b00, 0, '0, 0);
      // Johnson forward through all eight codes
      repeat (9) cycle(1, 0, 2'b01, 0, '0, 0);
      // Ring reverse
      repeat (5) cycle(1, 1, 2'b00, 0, '0, 0);
      // Illegal load then step: recovery vs plain shift
      cycle(0, 0, 2'b00, 1, 4'b0101, 0);
      cycle(1, 0, 2'b00, 0, '0, 0);
      cycle(1, 0, 2'b00, 0, '0, 0);
      // Mid-cycle async reset at 0100, then idle
      cycle(0, 0, 2'b00, 1, 4'b0001, 0);
      repeat (2) cycle(1, 0, 2'b00, 0, '0, 0);
      cycle(0, 0, 2'b00, 0, '0, 1);
      repeat (3) cycle(0, 0, 2'b00, 0, '0, 0);
      // Load and mode change on one edge; then hold mode
      cycle(1, 0, 2'b01, 1, 4'b1011, 0);
      cycle(1, 0, 2'b10, 0, '0, 0);
      repeat (3) cycle(1, 1, 2'b10, 0, '0, 0);
      cycle(0, 0, 2'b11, 1, 4'b0110, 0);
      cycle(1, 0, 2'b11, 0, '0, 0);
      // Reset release with a non-ring mode already applied
      cycle(1, 0, 2'b01, 0, '0, 1);
      cycle(1, 0, 2'b01, 0, '0, 0);

      rm = 2'b00;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rm,
               1'($urandom_range(0, 15) == 0), W'($urandom_range(0, 15)),
               $urandom_range(0, 99) == 0);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL drain actual=%0d required=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multimode_ring_counter.md
MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8; register width; WIDTH >= 2 is legal; WIDTH < 2 SHALL fail elaboration.
REQ-002 SHALL have parameter SELF_CORRECT, default 1; 1 enables recovery from illegal states.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1; step enable.
REQ-006 SHALL have port dir, input, 1; 0 = shift toward MSB, 1 = shift toward LSB.
REQ-007 SHALL have port mode, input, 2; 00 ring, 01 Johnson, 10/11 hold.
REQ-008 SHALL have port load, input, 1; synchronous parallel load strobe.
REQ-009 SHALL have port load_val, input, WIDTH; parallel load data.
REQ-010 SHALL have port q, output, WIDTH; counter state, registered.
REQ-011 SHALL have port wrap, output, 1; registered one-cycle pulse on sequence wrap.
REQ-012 SHALL have port err, output, 1; combinational illegal-state flag.

Function
REQ-013 Internal mode_q register SHALL hold the active mode; S0 = start state: ring 0...01, Johnson 0...00.
REQ-014 Per-edge priority, highest first: rst, mode change (mode != mode_q), load, en step; SHALL act on exactly one of them.
REQ-015 Mode change: q <= S0(mode) (hold modes: q unchanged), mode_q <= mode; load and en ignored that cycle.
REQ-016 Load: q <= load_val in any mode, regardless of en; no legality check on load.
REQ-017 Ring step, dir=0: q <= {q[W-2:0], q[W-1]}; dir=1: q <= {q[0], q[W-1:1]}.
REQ-018 Johnson step, dir=0: q <= {q[W-2:0], ~q[W-1]}; dir=1: q <= {~q[0], q[W-1:1]}.
REQ-019 Hold mode: q retains value; en ignored; load still honoured.
REQ-020 Legality: ring legal iff exactly one bit of q set; Johnson legal iff at most one adjacent pair q[i] != q[i+1] (exactly 2*WIDTH legal states).
REQ-021 err SHALL equal (q illegal for mode_q) while mode_q is ring or Johnson; 0 in hold.
REQ-022 SELF_CORRECT=1: an en step taken while err=1 SHALL load q <= S0(mode_q) instead of shifting; SELF_CORRECT=0: shift proceeds unmodified.
REQ-023 wrap SHALL be 1 for exactly the cycle q first equals S0 after a normal legal en step; 0 after load, mode change, correction, reset, or en=0 hold.
REQ-024 Wrap period: ring WIDTH steps, Johnson 2*WIDTH steps, either direction.
REQ-025 en=0 with no load/mode change: q, mode_q unchanged; wrap <= 0.

Reset
REQ-026 rst=1 SHALL immediately and asynchronously force q = 0...01, mode_q = 00, wrap = 0, independent of clk.
REQ-027 After rst deasserts, if mode != 00 the first edge SHALL apply the mode change per REQ-015.
REQ-028 Reset mid-sequence SHALL discard all in-flight state; no pulse on wrap on reset release.

Verification (WIDTH=4, SELF_CORRECT=1)
REQ-029 Reset, mode=00, dir=0, en=1 -> q 0001,0010,0100,1000,0001; wrap=1 only with the second 0001.
REQ-030 mode=01, dir=0, en=1 -> q 0000 next edge, then 0001,0011,0111,1111,1110,1100,1000,0000 with wrap=1 at the final 0000.
REQ-031 Ring, dir=1, from 0001 -> 1000 (wrap=0), 0100, 0010, 0001 (wrap=1).
REQ-032 Ring, load=1 load_val=0101 -> q=0101, err=1; next en step -> q=0001, err=0, wrap=0; repeat with SELF_CORRECT=0 -> q=1010, err stays 1.
REQ-033 Ring at q=0100, assert rst between edges -> q=0001 before next edge, wrap=0; en=0 for 3 edges -> q holds 0001.
REQ-034 Same edge load=1 and mode 00->01 -> q=0000 (mode change wins); hold mode with en=1 -> q frozen, err=0.
